// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box, FSM encoding, word/round constants, legal UNROLL set.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sm4_pkg;

   localparam int SM4_WORD_W = 32;
   localparam int SM4_ROUNDS = 32;
   localparam int SM4_UNROLL_LEGAL [4] = '{1, 2, 4, 8};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_HOLD  = 2'd2
   } sm4_state_e;

   localparam logic [7:0] SM4_SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   // Non-linear byte substitution applied to each byte of a word.
   function automatic logic [SM4_WORD_W-1:0] sm4_tau(input logic [SM4_WORD_W-1:0] a);
      return {SM4_SBOX[a[31:24]], SM4_SBOX[a[23:16]], SM4_SBOX[a[15:8]], SM4_SBOX[a[7:0]]};
   endfunction

   function automatic bit sm4_unroll_legal(input int u);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 4; i++)
         if (SM4_UNROLL_LEGAL[i] == u) ok = 1'b1;
      return ok;
   endfunction

endpackage

// File: rtl/one_round_for_encdec.sv
// One combinational SM4 round: {X0,X1,X2,X3} -> {X1,X2,X3,X0^T(X1^X2^X3^rk)}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: i_dat 128-bit state in (X0 in MSBs), i_rk round key, o_dat next state.
module one_round_for_encdec
   import sm4_pkg::*;
(
   input  logic [127:0]           i_dat,
   input  logic [SM4_WORD_W-1:0]  i_rk,
   output logic [127:0]           o_dat
);

   logic [SM4_WORD_W-1:0] w_t_in;
   logic [SM4_WORD_W-1:0] w_b;
   logic [SM4_WORD_W-1:0] w_l;

   assign w_t_in = i_dat[95:64] ^ i_dat[63:32] ^ i_dat[31:0] ^ i_rk;
   assign w_b    = sm4_tau(w_t_in);
   // Linear diffusion L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
   assign w_l    = w_b ^ {w_b[29:0], w_b[31:30]} ^ {w_b[21:0], w_b[31:22]}
                       ^ {w_b[13:0], w_b[31:14]} ^ {w_b[7:0],  w_b[31:8]};
   assign o_dat  = {i_dat[95:0], i_dat[127:96] ^ w_l};

endmodule

// File: rtl/sm4_encdec_pipe.sv
// Iterative SM4 encrypt/decrypt engine, UNROLL rounds per clock, optional CBC chaining.
// Latency: out_valid rises 32/UNROLL edges after acceptance; one block in flight at a time.
// Backpressure: result held in HOLD until out_ready; in_ready stays low until the cycle after.
// Ports: clk/reset; key_ready_in + rk_data_in (32 round keys); dec_in/cbc_in mode;
//        iv_load_in/iv_in chain load; in_valid/in_ready/in_data; out_valid/out_ready/out_data; busy.
module sm4_encdec_pipe
   import sm4_pkg::*;
#(
   parameter int UNROLL = 1,
   parameter int CBC_EN = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          key_ready_in,
   input  logic [1023:0] rk_data_in,
   input  logic          dec_in,
   input  logic          cbc_in,
   input  logic          iv_load_in,
   input  logic [127:0]  iv_in,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic          busy
);

   if (!sm4_unroll_legal(UNROLL)) begin : g_bad_unroll
      $error("sm4_encdec_pipe: UNROLL=%0d must be 1, 2, 4 or 8", UNROLL);
   end

   sm4_state_e    r_state, w_state_nxt;
   logic [4:0]    r_cnt;
   logic [127:0]  r_blk, r_ct, r_chain, r_out;
   logic          r_dec, r_cbc;

   logic          w_accept, w_out_hs, w_last, w_cbc_in;
   logic [127:0]  w_rev;
   logic [127:0]  w_x [UNROLL+1];

   assign w_cbc_in  = (CBC_EN != 0) ? cbc_in : 1'b0;
   assign in_ready  = (r_state == ST_IDLE) & key_ready_in & ~iv_load_in & ~reset;
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == ST_HOLD);
   assign w_out_hs  = out_valid & out_ready;
   assign busy      = (r_state != ST_IDLE);
   assign out_data  = r_out;
   assign w_last    = (r_cnt == 5'(SM4_ROUNDS - UNROLL));

   // Round chain: stage k evaluates round (r_cnt + k); decrypt walks the keys backwards.
   assign w_x[0] = r_blk;
   for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
      logic [4:0] w_j, w_ki;
      assign w_j  = r_cnt + 5'(k);
      assign w_ki = r_dec ? (5'd31 - w_j) : w_j;
      one_round_for_encdec u_round (
         .i_dat (w_x[k]),
         .i_rk  (rk_data_in[32*w_ki +: 32]),
         .o_dat (w_x[k+1])
      );
   end

   // Final state {X32,X33,X34,X35} is emitted word-reversed.
   assign w_rev = {w_x[UNROLL][31:0], w_x[UNROLL][63:32], w_x[UNROLL][95:64], w_x[UNROLL][127:96]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_ROUND;
         ST_ROUND: if (w_last)   w_state_nxt = ST_HOLD;
         ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_blk   <= '0;
         r_ct    <= '0;
         r_chain <= '0;
         r_out   <= '0;
         r_dec   <= 1'b0;
         r_cbc   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_blk <= (w_cbc_in & ~dec_in) ? (in_data ^ r_chain) : in_data;
            r_ct  <= in_data;
            r_dec <= dec_in;
            r_cbc <= w_cbc_in;
            r_cnt <= '0;
         end else if (r_state == ST_ROUND) begin
            r_blk <= w_x[UNROLL];
            if (w_last) begin
               r_cnt <= '0;
               r_out <= w_rev ^ ((r_cbc & r_dec) ? r_chain : 128'd0);
            end else begin
               r_cnt <= r_cnt + 5'(UNROLL);
            end
         end
         // in_ready excludes iv_load_in, so an IV load never coincides with acceptance.
         if ((CBC_EN != 0) && (r_state == ST_IDLE) && iv_load_in)
            r_chain <= iv_in;
         else if (w_out_hs && r_cbc)
            r_chain <= r_dec ? r_ct : r_out;
      end
   end

endmodule

// File: tb/tb_sm4_encdec_pipe.sv
module tb_sm4_encdec_pipe;
   import sm4_pkg::*;

   localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = PT ^ IV;   // CBC: E(P1^IV) = E(PT) = CT
   localparam logic [127:0] P2  = PT ^ CT;   // CBC: E(P2^CT) = E(PT) = CT

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key_ready_in = 1'b0;
   logic [1023:0] rk_data_in = '0;
   logic          dec_in = 1'b0, cbc_in = 1'b0, iv_load_in = 1'b0;
   logic [127:0]  iv_in = '0, in_data = '0;
   logic          in_valid = 1'b0, out_ready = 1'b1;
   logic          in_ready, out_valid, busy;
   logic [127:0]  out_data;

   typedef struct { logic [127:0] dat; int acc; } exp_t;
   exp_t exp_q[$];
   int   n_chk = 0, n_pass = 0, cyc = 0, first_acc = 0;
   logic prev_vld = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sm4_encdec_pipe #(.UNROLL(1), .CBC_EN(1)) u_dut (
      .clk(clk), .reset(reset), .key_ready_in(key_ready_in), .rk_data_in(rk_data_in),
      .dec_in(dec_in), .cbc_in(cbc_in), .iv_load_in(iv_load_in), .iv_in(iv_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Wider unrolls run the first block in parallel; only that block's result and latency are checked.
   for (genvar g = 1; g < 4; g++) begin : g_unr
      localparam int U = 1 << g;
      logic ir, ov, bz;
      logic [127:0] od;
      sm4_encdec_pipe #(.UNROLL(U), .CBC_EN(1)) u_dut (
         .clk(clk), .reset(reset), .key_ready_in(key_ready_in), .rk_data_in(rk_data_in),
         .dec_in(dec_in), .cbc_in(cbc_in), .iv_load_in(iv_load_in), .iv_in(iv_in),
         .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
         .out_valid(ov), .out_ready(out_ready), .out_data(od), .busy(bz));
      initial begin
         int n;
         n = 0;
         wait (first_acc != 0);
         while (!ov && n < 100) begin @(negedge clk); n++; end
         chk($sformatf("u%0d_latency", U), 128'(cyc - first_acc), 128'(32 / U));
         chk($sformatf("u%0d_ecb_enc", U), od, CT);
      end
   end

   // Monitor: latency on out_valid rise, data on each output handshake.
   always begin
      @(negedge clk);
      #1;
      if (!reset) begin
         if (out_valid && !prev_vld) begin
            if (exp_q.size() == 0) chk("unexpected_vld", 128'(out_valid), 128'd0);
            else chk("latency", 128'(cyc - exp_q[0].acc), 128'd32);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 128'(out_valid), 128'd0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", out_data, e.dat);
            end
         end
      end
      prev_vld = out_valid;
   end

   function automatic logic [1023:0] expand(input logic [127:0] mk);
      logic [31:0] k [36];
      logic [31:0] fk [4];
      logic [31:0] t, ck, b;
      logic [1023:0] rk;
      fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
      rk = '0;
      for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
         t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck;
         for (int j = 0; j < 4; j++) b[8*j +: 8] = SM4_SBOX[t[8*j +: 8]];
         k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
         rk[32*i +: 32] = k[i+4];
      end
      return rk;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      if (busy) chk("idle_timeout", 128'(busy), 128'd0);
   endtask

   task automatic send(input logic [127:0] d, input logic dec, input logic cbc,
                       input bit push, input logic [127:0] e);
      int n;
      n = 0;
      @(negedge clk);
      in_data = d; dec_in = dec; cbc_in = cbc; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
      if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
      else begin
         if (push) exp_q.push_back('{dat: e, acc: cyc + 1});
         if (first_acc == 0) first_acc = cyc + 1;
      end
      @(negedge clk);
      // Scramble mode/data inputs: the block in flight must ignore them.
      in_valid = 1'b0; in_data = ~d; dec_in = ~dec; cbc_in = ~cbc;
   endtask

   task automatic load_iv(input logic [127:0] v);
      wait_idle();
      @(negedge clk); iv_load_in = 1'b1; iv_in = v;
      @(negedge clk); iv_load_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, seen;
      rk_data_in = expand(KEY);
      @(negedge clk); #1;
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      @(negedge clk);
      reset = 1'b0; key_ready_in = 1'b1;
      @(negedge clk); #1;
      chk("post_rst_in_ready", 128'(in_ready), 128'd1);

      // ECB encrypt / decrypt of the standard vector
      send(PT, 1'b0, 1'b0, 1'b1, CT);
      send(CT, 1'b1, 1'b0, 1'b1, PT);

      // CBC encrypt two blocks, then decrypt them with the same IV
      load_iv(IV);
      send(P1, 1'b0, 1'b1, 1'b1, CT);
      send(P2, 1'b0, 1'b1, 1'b1, CT);
      load_iv(IV);
      send(CT, 1'b1, 1'b1, 1'b1, P1);
      send(CT, 1'b1, 1'b1, 1'b1, P2);

      // Backpressure on an ECB block; IV load and in_valid during HOLD must be ignored
      load_iv(IV);
      out_ready = 1'b0;
      send(CT, 1'b1, 1'b0, 1'b1, PT);
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) chk("hold_timeout", 128'(out_valid), 128'd1);
      in_valid = 1'b1; in_data = P2; dec_in = 1'b0; cbc_in = 1'b1;
      iv_load_in = 1'b1; iv_in = ~IV;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("hold_data", out_data, PT);
         chk("hold_in_ready", 128'(in_ready), 128'd0);
         if (i == 4) iv_load_in = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      // Chain must still be IV: ECB left it alone and the HOLD-state load was dropped
      send(P1, 1'b0, 1'b1, 1'b1, CT);

      // in_ready tracks key_ready_in
      wait_idle();
      @(negedge clk); key_ready_in = 1'b0; #1;
      chk("key_not_ready", 128'(in_ready), 128'd0);
      key_ready_in = 1'b1; #1;
      chk("key_ready", 128'(in_ready), 128'd1);

      // Reset at round 7 discards the block and clears the chain
      send(PT, 1'b0, 1'b0, 1'b0, 128'd0);
      repeat (7) @(negedge clk);
      reset = 1'b1; #1;
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
      chk("mid_rst_out_data", out_data, 128'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("no_vld_after_rst", 128'(seen), 128'd0);
      send(PT, 1'b0, 1'b1, 1'b1, CT);

      // IV load beats in_valid; the block goes in on the following cycle
      wait_idle();
      @(negedge clk);
      iv_load_in = 1'b1; iv_in = IV; in_valid = 1'b1; in_data = P1; dec_in = 1'b0; cbc_in = 1'b1;
      #1;
      chk("ivld_in_ready_lo", 128'(in_ready), 128'd0);
      @(negedge clk);
      iv_load_in = 1'b0; #1;
      chk("ivld_not_accepted", 128'(busy), 128'd0);
      chk("ivld_in_ready_hi", 128'(in_ready), 128'd1);
      exp_q.push_back('{dat: CT, acc: cyc + 1});
      @(negedge clk);
      in_valid = 1'b0; #1;
      chk("ivld_accepted", 128'(busy), 128'd1);

      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      chk("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
